pipeline_credit_buffer: RTL and testbench

//  Elastic output buffer placed directly after a fixed-latency, non-stallable

---
 rtl/pipeline_credit_buffer.sv | 70 +++++++
 tb/tb_pipeline_credit_buffer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_credit_buffer.sv
// pipeline_credit_buffer: credit-reserving elastic FIFO behind a non-stallable pipeline
//   clk          rising-edge clock
//   reset_n      async active-low reset
//   issue        upstream launches an item into the pipeline this cycle
//   issue_ready  a slot is free for a new launch
//   in_valid     pipeline output carries a valid item
//   in_data      pipeline output data
//   out_valid    FIFO head is valid
//   out_ready    consumer accepts the head
//   out_data     FIFO head data
//   count        entries currently stored (0..DEPTH)
//   err_overflow sticky: item arrived with no free slot
//   err_orphan   sticky: item arrived with nothing in flight
module pipeline_credit_buffer #(
    parameter int BIT_WIDTH  = 10,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  issue,
    output logic                  issue_ready,
    input  logic                  in_valid,
    input  logic [BIT_WIDTH-1:0]  in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BIT_WIDTH-1:0]  out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  err_overflow,
    output logic                  err_orphan
);
    localparam logic [ADDR_WIDTH:0] FULL = (ADDR_WIDTH+1)'(DEPTH);
    logic [BIT_WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   reserved;
    logic                  issue_acc;
    logic                  pop;
    logic                  write;
    always_comb begin
        issue_ready = reserved < FULL;
        out_valid   = count != '0;
        out_data    = mem[rd_ptr];
        issue_acc   = issue & issue_ready;
        pop         = out_valid & out_ready;
        // a pop in the same cycle frees the slot, so a full FIFO still accepts
        write       = in_valid & ((count != FULL) | pop);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            reserved     <= '0;
            err_overflow <= 1'b0;
            err_orphan   <= 1'b0;
        end else begin
            if (write) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            if (pop) rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            count    <= count + (ADDR_WIDTH+1)'(write) - (ADDR_WIDTH+1)'(pop);
            reserved <= reserved + (ADDR_WIDTH+1)'(issue_acc) - (ADDR_WIDTH+1)'(pop);
            if (in_valid & ~write) err_overflow <= 1'b1;
            // reserved == count means no launch is outstanding, so this item was never credited
            if (in_valid && reserved == count) err_orphan <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (write) mem[wr_ptr] <= in_data;
    end
endmodule

// File: tb/tb_pipeline_credit_buffer.sv
// tb_pipeline_credit_buffer: directed checks of the credit buffer behind a 3-stage pipeline model
module tb_pipeline_credit_buffer;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       issue = 1'b0;
    logic       issue_ready;
    logic       in_valid;
    logic [9:0] in_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [9:0] out_data;
    logic [3:0] count;
    logic       err_overflow;
    logic       err_orphan;
    logic       direct = 1'b0;
    logic       dv = 1'b0;
    logic [9:0] dd = '0;
    logic [2:0] pv;
    logic [9:0] pd [3];
    logic [9:0] seq;
    int         acc_cnt;
    int         errors = 0;
    int         checks = 0;

    pipeline_credit_buffer #(.BIT_WIDTH(10), .DEPTH(8), .ADDR_WIDTH(3)) dut (
        .clk(clk), .reset_n(reset_n), .issue(issue), .issue_ready(issue_ready),
        .in_valid(in_valid), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .count(count),
        .err_overflow(err_overflow), .err_orphan(err_orphan)
    );

    always #5 clk = ~clk;

    // 3-stage non-stallable pipeline; launches carry an incrementing sequence number
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pv      <= '0;
            pd[0]   <= '0;
            pd[1]   <= '0;
            pd[2]   <= '0;
            seq     <= '0;
            acc_cnt <= 0;
        end else begin
            pv    <= {pv[1:0], issue & issue_ready};
            pd[0] <= seq;
            pd[1] <= pd[0];
            pd[2] <= pd[1];
            if (issue & issue_ready) begin
                seq     <= seq + 10'd1;
                acc_cnt <= acc_cnt + 1;
            end
        end
    end

    assign in_valid = direct ? dv : pv[2];
    assign in_data  = direct ? dd : pd[2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        issue     = 1'b0;
        out_ready = 1'b0;
        direct    = 1'b0;
        dv        = 1'b0;
        step();
        step();
        reset_n = 1'b1;
    endtask

    function automatic logic [9:0] pat(input int i);
        return ((i % 2) != 0 ? 10'h2AA : 10'h155) ^ 10'(i);
    endfunction

    initial begin
        logic       prev_iv;
        logic [9:0] exp_data;
        logic [9:0] q [$];
        // reset state
        do_reset();
        check("rst_out_valid", out_valid, 0);
        check("rst_issue_ready", issue_ready, 1);
        check("rst_count", count, 0);
        check("rst_err_overflow", err_overflow, 0);
        check("rst_err_orphan", err_orphan, 0);
        // streaming: issue every cycle, consumer always ready
        issue     = 1'b1;
        out_ready = 1'b1;
        prev_iv   = in_valid;
        exp_data  = '0;
        for (int i = 0; i < 18; i++) begin
            if (i == 12) issue = 1'b0;
            step();
            check("stream_issue_ready", issue_ready, 1);
            check("stream_count_le1", (count <= 4'd1) ? 1 : 0, 1);
            check("stream_latency", out_valid, prev_iv);
            if (out_valid) begin
                check("stream_data", out_data, exp_data);
                exp_data = exp_data + 10'd1;
            end
            prev_iv = in_valid;
        end
        check("stream_delivered", exp_data, 12);
        check("stream_count_end", count, 0);
        // fill with consumer stalled
        do_reset();
        issue     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 14; i++) begin
            step();
            check("fill_issue_ready", issue_ready, (acc_cnt < 8) ? 1 : 0);
        end
        check("fill_accepted", acc_cnt, 8);
        check("fill_count", count, 8);
        check("fill_err_overflow", err_overflow, 0);
        check("fill_err_orphan", err_orphan, 0);
        check("fill_head", out_data, 0);
        // one pop from full with an issue pending
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pop_issue_ready", issue_ready, 1);
        check("pop_count", count, 7);
        check("pop_head", out_data, 1);
        step();
        check("refill_accepted", acc_cnt, 9);
        check("refill_issue_ready", issue_ready, 0);
        issue = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("refill_count", count, 8);
        check("refill_head", out_data, 1);
        // overflow: forced push while full and not popping
        direct = 1'b1;
        dv     = 1'b1;
        dd     = 10'h3FF;
        step();
        dv = 1'b0;
        check("ovf_flag", err_overflow, 1);
        check("ovf_count", count, 8);
        check("ovf_head", out_data, 1);
        // full with simultaneous push and pop
        for (int i = 1; i <= 8; i++) q.push_back(10'(i));
        issue     = 1'b1;
        out_ready = 1'b1;
        dv        = 1'b1;
        for (int i = 0; i < 20; i++) begin
            dd = pat(i);
            check("full_count", count, 8);
            check("full_data", out_data, q[0]);
            step();
            void'(q.pop_front());
            q.push_back(pat(i));
        end
        dv = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, q[0]);
            step();
            void'(q.pop_front());
        end
        check("drain_count", count, 0);
        check("drain_out_valid", out_valid, 0);
        // orphan: push with nothing reserved
        do_reset();
        check("orph_pre", err_orphan, 0);
        direct = 1'b1;
        dv     = 1'b1;
        dd     = 10'h0AB;
        step();
        dv = 1'b0;
        check("orph_flag", err_orphan, 1);
        check("orph_no_ovf", err_overflow, 0);
        check("orph_count", count, 1);
        check("orph_head", out_data, 10'h0AB);
        // asynchronous reset mid-cycle with five entries stored
        do_reset();
        issue     = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) step();
        issue = 1'b0;
        for (int i = 0; i < 4; i++) step();
        check("arst_pre_count", count, 5);
        check("arst_pre_valid", out_valid, 1);
        #3;
        reset_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_count", count, 0);
        check("arst_issue_ready", issue_ready, 1);
        step();
        reset_n = 1'b1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
